aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Top-level sequencer for one AES encryption: on start, optionally reruns the key-expansion unit
//  (one 32-bit word per enabled cycle), then steps the round datapath through initial AddRoundKey,
//  Nr-1 full rounds and the final round. Drives the expansion unit's sync reset/enable and the
//  datapath's round index/strobes. Expanded keys are cached across blocks until key_changed.
// PARAMETERS
//  NK  4  key length in 32-bit words; legal 4/6/8 only (AES-128/192/256); NR = NK+6 derived
//  KX_WORDS  derived = 4*(NK+7)  expansion cycles (44/52/60)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-low reset
//  start        in   1  request one block; accepted only in IDLE
//  key_changed  in   1  qualifies start: 1 = rerun key expansion before rounds
//  kx_reset     out  1  sync active-high reset pulse to key-expansion unit
//  kx_enable    out  1  key-expansion advance strobe, one word per cycle
//  round_idx    out  4  round key / round number for datapath (0..NR)
//  load_state   out  1  datapath: state <= plaintext ^ roundkey[0]
//  do_round     out  1  datapath: perform one round using roundkey[round_idx]
//  last_round   out  1  with do_round: omit MixColumns
//  busy         out  1  high from accepted start through DONE
//  done         out  1  one-cycle pulse: ciphertext valid on datapath output
//  keys_ready   out  1  expanded key set is valid for current key
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, kx_count=0, round_idx=0, keys_ready=0; all strobes,
//   busy, done = 0. Reset mid-operation aborts immediately; no done issued; keys must be re-expanded.
//  States: IDLE, KX_CLR, KX_RUN, INIT_ARK, ROUND, FINAL, DONE (registered outputs decoded from state).
//  IDLE: start=1 & (key_changed=1 | keys_ready=0) -> KX_CLR; start=1 otherwise -> INIT_ARK.
//   start=0 -> stay. start/key_changed ignored in every other state (no queuing).
//  KX_CLR: 1 cycle, kx_reset=1, keys_ready<=0, kx_count<=0 -> KX_RUN.
//  KX_RUN: kx_enable=1 for exactly KX_WORDS consecutive cycles; kx_count increments each cycle;
//   at kx_count==KX_WORDS-1 -> INIT_ARK, keys_ready<=1 on the same edge.
//  INIT_ARK: 1 cycle, load_state=1, round_idx=0 -> ROUND with round_idx=1.
//  ROUND: do_round=1, round_idx increments each cycle; leaves after round_idx==NR-1 -> FINAL.
//  FINAL: 1 cycle, do_round=1, last_round=1, round_idx=NR -> DONE.
//  DONE: 1 cycle, done=1, round_idx<=0 -> IDLE. busy=0 in IDLE only.
//  Latency (start edge to done high): cached keys NR+2 cycles (12/14/16);
//   with expansion add 1+KX_WORDS (57/67/77 total).
//  Back-to-back: start asserted in the cycle done is high is ignored (state still DONE);
//   earliest accept is the following cycle (IDLE).
//  Counters: kx_count 6 bits, round_idx 4 bits; never wrap (bounded by state exits).
//  At most one of kx_reset/kx_enable/load_state/do_round high in any cycle.
//  Requester holds key and plaintext stable while busy=1.
//  Illegal NK: elaboration-time error (generate-time check), no runtime behaviour defined.
// TESTING
//  1 NK=4, reset release, start=1,key_changed=0 (keys_ready=0) -> kx_reset 1 cyc, kx_enable 44 cyc,
//    done 57 cycles after start; FIPS-197 C.1 key/pt -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//  2 NK=4, second start, key_changed=0 -> no kx_enable; round_idx 0,1..10; done after 12 cycles;
//    last_round high only when round_idx=10.
//  3 NK=6 and NK=8 with key_changed=1 -> kx_enable 52/60 cycles, done at 67/77; FIPS C.2/C.3 ct.
//  4 start pulsed in every cycle while busy -> ignored; exactly one done; busy low 1 cycle between blocks.
//  5 reset=0 during KX_RUN (cycle 20) -> outputs 0 same cycle; keys_ready=0; next start reruns expansion.
//  6 reset=0 during ROUND (round_idx=5), then start key_changed=0 -> full expansion (keys_ready lost).

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control sequencer for one AES encryption: optional key-expansion rerun, then the initial
// AddRoundKey, NR-1 full rounds and the final round. Expanded keys persist across blocks.
module aes_round_sequencer #(
    parameter int NK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_changed,
    output logic       kx_reset,
    output logic       kx_enable,
    output logic [3:0] round_idx,
    output logic       load_state,
    output logic       do_round,
    output logic       last_round,
    output logic       busy,
    output logic       done,
    output logic       keys_ready
);
    localparam int NR       = NK + 6;
    localparam int KX_WORDS = 4 * (NK + 7);

    localparam logic [3:0] LAST_FULL_ROUND = 4'(NR - 1);
    localparam logic [5:0] KX_LAST         = 6'(KX_WORDS - 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_illegal_nk
            $error("aes_round_sequencer: NK must be 4, 6 or 8 (got %0d)", NK);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        KX_CLR,
        KX_RUN,
        INIT_ARK,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t     state_q;
    logic [5:0] kxCount_q;
    logic [3:0] roundIdx_q;
    logic       kxReset_q;
    logic       kxEnable_q;
    logic       loadState_q;
    logic       doRound_q;
    logic       lastRound_q;
    logic       busy_q;
    logic       done_q;
    logic       keysReady_q;

    // Outputs are registered alongside the state, so each strobe is set on the edge that
    // enters the state it belongs to and cleared on the edge that leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            kxCount_q   <= '0;
            roundIdx_q  <= '0;
            kxReset_q   <= 1'b0;
            kxEnable_q  <= 1'b0;
            loadState_q <= 1'b0;
            doRound_q   <= 1'b0;
            lastRound_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            keysReady_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (key_changed || !keysReady_q) begin
                            state_q     <= KX_CLR;
                            kxReset_q   <= 1'b1;
                            keysReady_q <= 1'b0;
                            kxCount_q   <= '0;
                        end else begin
                            state_q     <= INIT_ARK;
                            loadState_q <= 1'b1;
                            roundIdx_q  <= '0;
                        end
                    end
                end
                KX_CLR: begin
                    state_q    <= KX_RUN;
                    kxReset_q  <= 1'b0;
                    kxEnable_q <= 1'b1;
                end
                KX_RUN: begin
                    kxCount_q <= kxCount_q + 6'd1;
                    if (kxCount_q == KX_LAST) begin
                        state_q     <= INIT_ARK;
                        kxEnable_q  <= 1'b0;
                        keysReady_q <= 1'b1;
                        loadState_q <= 1'b1;
                        roundIdx_q  <= '0;
                    end
                end
                INIT_ARK: begin
                    state_q     <= ROUND;
                    loadState_q <= 1'b0;
                    doRound_q   <= 1'b1;
                    roundIdx_q  <= 4'd1;
                end
                ROUND: begin
                    // The increment out of the last full round lands exactly on NR for FINAL.
                    roundIdx_q <= roundIdx_q + 4'd1;
                    if (roundIdx_q == LAST_FULL_ROUND) begin
                        state_q     <= FINAL;
                        lastRound_q <= 1'b1;
                    end
                end
                FINAL: begin
                    state_q     <= DONE;
                    doRound_q   <= 1'b0;
                    lastRound_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    roundIdx_q <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    kxReset_q   <= 1'b0;
                    kxEnable_q  <= 1'b0;
                    loadState_q <= 1'b0;
                    doRound_q   <= 1'b0;
                    lastRound_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    roundIdx_q  <= '0;
                end
            endcase
        end
    end

    assign kx_reset   = kxReset_q;
    assign kx_enable  = kxEnable_q;
    assign round_idx  = roundIdx_q;
    assign load_state = loadState_q;
    assign do_round   = doRound_q;
    assign last_round = lastRound_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_ready = keysReady_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: one instance each of NK=4/6/8, directed starts with
// hand-computed latencies and expansion lengths, checked by a single monitor process.
module tb_aes_round_sequencer;

    typedef struct packed {
        int startCyc;
        int latency;
        int kxWords;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] startV = '0;
    logic [2:0] keyChgV = '0;

    logic [2:0] kxReset, kxEnable, loadState, doRound, lastRound, busy, done, keysReady;
    logic [3:0] roundIdx [3];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   lastStart = 0;
    bit   endReq = 1'b0;
    bit   endAck = 1'b0;
    exp_t sbQ [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_sequencer #(.NK(4 + 2 * g)) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (startV[g]),
            .key_changed(keyChgV[g]),
            .kx_reset   (kxReset[g]),
            .kx_enable  (kxEnable[g]),
            .round_idx  (roundIdx[g]),
            .load_state (loadState[g]),
            .do_round   (doRound[g]),
            .last_round (lastRound[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .keys_ready (keysReady[g])
        );
    end

    int   kxSeen [3];
    int   clrSeen [3];
    int   loadSeen [3];
    int   expRound [3];
    bit   krModel [3];
    exp_t e;
    bit   busyExp;
    int   nr;

    // Monitor: wakes 1 time unit after every falling clock edge or reset assertion, checks
    // per-cycle invariants and retires scoreboard entries whenever done is presented.
    always begin : monitor
        @(negedge clk or negedge reset);
        #1;
        for (int i = 0; i < 3; i++) begin
            nr = 10 + 2 * i;
            if (reset == 1'b0) begin
                checks++;
                if ({kxReset[i], kxEnable[i], loadState[i], doRound[i], lastRound[i],
                     busy[i], done[i], keysReady[i], roundIdx[i]} != '0) begin
                    errors++;
                    $display("[TB] FAIL reset_outputs nk=%0d got=%b%b%b%b%b%b%b%b idx=%0d want=all 0",
                             4 + 2 * i, kxReset[i], kxEnable[i], loadState[i], doRound[i],
                             lastRound[i], busy[i], done[i], keysReady[i], roundIdx[i]);
                end
                sbQ[i].delete();
                kxSeen[i] = 0;
                clrSeen[i] = 0;
                loadSeen[i] = 0;
                expRound[i] = 0;
                krModel[i] = 1'b0;
            end else begin
                busyExp = 1'b0;
                if (sbQ[i].size() != 0) begin
                    e = sbQ[i][0];
                    busyExp = (cyc > e.startCyc);
                    if (e.kxWords != 0 && cyc > e.startCyc)
                        krModel[i] = (cyc >= e.startCyc + 2 + e.kxWords);
                end
                checks++;
                if (busy[i] !== busyExp) begin
                    errors++;
                    $display("[TB] FAIL busy nk=%0d cyc=%0d got=%b want=%b", 4 + 2 * i, cyc, busy[i], busyExp);
                end
                checks++;
                if (keysReady[i] !== krModel[i]) begin
                    errors++;
                    $display("[TB] FAIL keys_ready nk=%0d cyc=%0d got=%b want=%b",
                             4 + 2 * i, cyc, keysReady[i], krModel[i]);
                end
                checks++;
                if ($countones({kxReset[i], kxEnable[i], loadState[i], doRound[i]}) > 1 ||
                    (lastRound[i] && !doRound[i])) begin
                    errors++;
                    $display("[TB] FAIL strobes nk=%0d cyc=%0d got=%b%b%b%b last=%b want=at most one strobe",
                             4 + 2 * i, cyc, kxReset[i], kxEnable[i], loadState[i], doRound[i], lastRound[i]);
                end
                if (kxReset[i]) clrSeen[i]++;
                if (kxEnable[i]) kxSeen[i]++;
                if (loadState[i]) begin
                    loadSeen[i]++;
                    checks++;
                    if (roundIdx[i] != 4'd0) begin
                        errors++;
                        $display("[TB] FAIL init_ark_idx nk=%0d got=%0d want=0", 4 + 2 * i, roundIdx[i]);
                    end
                    expRound[i] = 1;
                end
                if (doRound[i]) begin
                    checks++;
                    if (roundIdx[i] != 4'(expRound[i]) || lastRound[i] != (expRound[i] == nr)) begin
                        errors++;
                        $display("[TB] FAIL round_seq nk=%0d got idx=%0d last=%b want idx=%0d last=%b",
                                 4 + 2 * i, roundIdx[i], lastRound[i], expRound[i], expRound[i] == nr);
                    end
                    expRound[i]++;
                end
                if (done[i]) begin
                    checks++;
                    if (sbQ[i].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_done nk=%0d cyc=%0d got=done want=no done", 4 + 2 * i, cyc);
                    end else begin
                        e = sbQ[i].pop_front();
                        if (cyc - e.startCyc != e.latency) begin
                            errors++;
                            $display("[TB] FAIL latency nk=%0d got=%0d want=%0d", 4 + 2 * i, cyc - e.startCyc, e.latency);
                        end
                        checks++;
                        if (kxSeen[i] != e.kxWords || clrSeen[i] != (e.kxWords != 0 ? 1 : 0)) begin
                            errors++;
                            $display("[TB] FAIL kx_strobes nk=%0d got enable=%0d reset=%0d want enable=%0d reset=%0d",
                                     4 + 2 * i, kxSeen[i], clrSeen[i], e.kxWords, e.kxWords != 0 ? 1 : 0);
                        end
                        checks++;
                        if (loadSeen[i] != 1 || expRound[i] != nr + 1) begin
                            errors++;
                            $display("[TB] FAIL round_count nk=%0d got loads=%0d rounds=%0d want loads=1 rounds=%0d",
                                     4 + 2 * i, loadSeen[i], expRound[i] - 1, nr);
                        end
                    end
                    kxSeen[i] = 0;
                    clrSeen[i] = 0;
                    loadSeen[i] = 0;
                    expRound[i] = 0;
                end
            end
        end
        if (endReq && !endAck) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sbQ[i].size() != 0) begin
                    errors++;
                    $display("[TB] FAIL missing_done nk=%0d got=%0d pending want=0", 4 + 2 * i, sbQ[i].size());
                end
            end
            endAck = 1'b1;
        end
    end

    task automatic applyStimulus(input int idx, input bit kc, input int latency, input int kxWords);
        exp_t ent;
        @(negedge clk);
        startV[idx] = 1'b1;
        keyChgV[idx] = kc;
        ent.startCyc = cyc;
        ent.latency = latency;
        ent.kxWords = kxWords;
        lastStart = cyc;
        sbQ[idx].push_back(ent);
        @(negedge clk);
        startV[idx] = 1'b0;
        keyChgV[idx] = 1'b0;
    endtask

    task automatic waitIdle(input int idx, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sbQ[idx].size() == 0 && !busy[idx]) break;
        end
    endtask

    task automatic pulseReset();
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin : stimulus
        exp_t ent;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        $display("[TB] first start with no keys: expansion forced");
        applyStimulus(0, 1'b0, 57, 44);
        waitIdle(0, 100);

        $display("[TB] cached keys");
        applyStimulus(0, 1'b0, 12, 0);
        waitIdle(0, 40);
        applyStimulus(0, 1'b1, 57, 44);
        waitIdle(0, 100);

        $display("[TB] NK=6 and NK=8 expansion and cached runs");
        applyStimulus(1, 1'b1, 67, 52);
        applyStimulus(2, 1'b1, 77, 60);
        waitIdle(1, 100);
        waitIdle(2, 100);
        applyStimulus(1, 1'b0, 14, 0);
        applyStimulus(2, 1'b0, 16, 0);
        waitIdle(1, 40);
        waitIdle(2, 40);
        applyStimulus(1, 1'b1, 67, 52);
        waitIdle(1, 100);

        $display("[TB] start held high across a whole block");
        @(negedge clk);
        startV[0] = 1'b1;
        ent.startCyc = cyc;
        ent.latency = 12;
        ent.kxWords = 0;
        sbQ[0].push_back(ent);
        repeat (13) @(negedge clk);
        ent.startCyc = cyc;
        sbQ[0].push_back(ent);
        @(negedge clk);
        startV[0] = 1'b0;
        waitIdle(0, 40);

        $display("[TB] reset during key expansion");
        applyStimulus(0, 1'b1, 57, 44);
        while (cyc < lastStart + 22) @(negedge clk);
        pulseReset();
        applyStimulus(0, 1'b0, 57, 44);
        waitIdle(0, 100);

        $display("[TB] reset during rounds");
        applyStimulus(0, 1'b0, 12, 0);
        while (cyc < lastStart + 6) @(negedge clk);
        pulseReset();
        applyStimulus(0, 1'b0, 57, 44);
        waitIdle(0, 100);

        endReq = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
